// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_sub cell processes one bit per clock,
// LSB first, with the borrow carried between bits in a register.

module full_sub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic differ,
  output logic barrow
);
  assign differ = a ^ b ^ c;
  assign barrow = (~a & b) | (~a & c) | (b & c);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] differ_out,
  output logic             barrow_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] differ_out_q, differ_out_d;
  logic             barrow_out_q, barrow_out_d;
  logic             fs_differ_s, fs_barrow_s;

  full_sub u_full_sub (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .c      (borrow_q),
    .differ (fs_differ_s),
    .barrow (fs_barrow_s)
  );

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_sh_d     = res_sh_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    differ_out_d = differ_out_q;
    barrow_out_d = barrow_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SHIFT;
          a_sh_d       = a_in;
          b_sh_d       = b_in;
          borrow_d     = bin;
          cnt_d        = {CW{1'b0}};
          differ_out_d = {WIDTH{1'b0}};
          barrow_out_d = 1'b0;
          busy_d       = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      SHIFT: begin
        // Difference bits enter at the MSB so the last bit lands the word in place.
        res_sh_d = {fs_differ_s, res_sh_q[WIDTH-1:1]};
        borrow_d = fs_barrow_s;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        busy_d   = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d      = DONE;
          differ_out_d = {fs_differ_s, res_sh_q[WIDTH-1:1]};
          barrow_out_d = fs_barrow_s;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= {WIDTH{1'b0}};
      b_sh_q       <= {WIDTH{1'b0}};
      res_sh_q     <= {WIDTH{1'b0}};
      borrow_q     <= 1'b0;
      cnt_q        <= {CW{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      differ_out_q <= {WIDTH{1'b0}};
      barrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_sh_q     <= res_sh_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      differ_out_q <= differ_out_d;
      barrow_out_q <= barrow_out_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign differ_out = differ_out_q;
  assign barrow_out = barrow_out_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random self-checking bench for serial_sub_ctrl at WIDTH=8.

module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         bin = 1'b0;
  logic         busy, done, barrow_out;
  logic [W-1:0] differ_out;

  int errors = 0;
  int checks = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .bin(bin), .busy(busy), .done(done), .differ_out(differ_out),
    .barrow_out(barrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and check latency, result and return to idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] ref_v;
    int lat;
    ref_v = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    a_in = a; b_in = b; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
    a_in = ~a; b_in = ~b; bin = ~bi;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    check("done_latency", lat, W);
    check("differ_out", {24'd0, differ_out}, {24'd0, ref_v[W-1:0]});
    check("barrow_out", {31'd0, barrow_out}, {31'd0, ref_v[W]});
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
    check("differ_hold", {24'd0, differ_out}, {24'd0, ref_v[W-1:0]});
  endtask

  initial begin
    int seen;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_differ", {24'd0, differ_out}, 32'd0);
    check("rst_barrow", {31'd0, barrow_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h03, 8'h05, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1);

    // Start held high: back-to-back operations every W+2 cycles.
    a_in = 8'h10; b_in = 8'h01; bin = 1'b0; start = 1'b1;
    tick();
    for (int op = 0; op < 3; op++) begin
      check("hold_busy", {31'd0, busy}, 32'd1);
      a_in = 8'hAA; b_in = 8'h55; bin = 1'b1;
      for (int i = 0; i < W - 1; i++) begin
        tick();
        check("hold_no_early_done", {31'd0, done}, 32'd0);
      end
      tick();
      check("hold_done", {31'd0, done}, 32'd1);
      check("hold_differ", {24'd0, differ_out}, 32'h0F);
      check("hold_barrow", {31'd0, barrow_out}, 32'd0);
      a_in = 8'h10; b_in = 8'h01; bin = 1'b0;
      tick();
      check("hold_gap_done", {31'd0, done}, 32'd0);
      check("hold_gap_busy", {31'd0, busy}, 32'd0);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Asynchronous reset in the middle of SHIFT.
    a_in = 8'h33; b_in = 8'h11; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_differ", {24'd0, differ_out}, 32'd0);
    check("mid_rst_barrow", {31'd0, barrow_out}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) seen++;
    end
    check("no_done_after_abort", seen, 0);
    run_op(8'h33, 8'h11, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
